pipelined_accumulator_engine: RTL and testbench

//   Parametrised, handshaked successor of the ROM-indexed adding machine. Sums (or subtracts) the

---
 rtl/pipelined_acc_pkg.sv | 14 +
 rtl/acc_operand_mem.sv | 24 ++
 rtl/pipelined_accumulator_engine.sv | 103 ++++++++++
 tb/tb_pipelined_accumulator_engine.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pipelined_acc_pkg.sv
// rtl/pipelined_acc_pkg.sv - shared state encoding and mode constants for the accumulator engine
package pipelined_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/acc_operand_mem.sv
// rtl/acc_operand_mem.sv - DEPTH x WIDTH operand table, synchronous write, combinational read
// Deliberately unreset so the table contents survive an engine reset.
module acc_operand_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pipelined_accumulator_engine.sv
// rtl/pipelined_accumulator_engine.sv - fetch/accumulate pipeline over the operand table
// Optional feature: ACC_SATURATE_EN clamps the sum on carry/borrow instead of wrapping.
module pipelined_accumulator_engine
  import pipelined_acc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  input  logic [AW:0]      len,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);

  state_t           state;
  logic [AW-1:0]    idx;
  logic [AW:0]      n_reg;
  logic             mode_reg;
  logic [WIDTH-1:0] pipe_data;
  logic             pipe_valid;
  logic [WIDTH-1:0] rd_data;
  logic [AW:0]      len_eff;
  logic [WIDTH:0]   acc_ext;
  logic [WIDTH-1:0] sum_next;

  acc_operand_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (wr_en && (state == IDLE)),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (idx),
    .rdata (rd_data)
  );

  assign len_eff = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;

  // Bit WIDTH of the extended result is the carry (add) or borrow (sub).
  always_comb begin
    acc_ext = '0;
    if (mode_reg == MODE_SUB) acc_ext = {1'b0, sum} - {1'b0, pipe_data};
    else                      acc_ext = {1'b0, sum} + {1'b0, pipe_data};
    sum_next = acc_ext[WIDTH-1:0];
`ifdef ACC_SATURATE_EN
    if (acc_ext[WIDTH]) sum_next = (mode_reg == MODE_SUB) ? '0 : '1;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      n_reg      <= '0;
      mode_reg   <= MODE_ADD;
      pipe_data  <= '0;
      pipe_valid <= 1'b0;
      sum        <= '0;
      overflow   <= 1'b0;
    end else begin
      if (pipe_valid) begin
        sum      <= sum_next;
        overflow <= overflow | acc_ext[WIDTH];
      end
      case (state)
        IDLE: begin
          if (start) begin
            n_reg      <= len_eff;
            mode_reg   <= mode;
            sum        <= '0;
            overflow   <= 1'b0;
            idx        <= '0;
            pipe_valid <= 1'b0;
            state      <= (len_eff == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          pipe_data  <= rd_data;
          pipe_valid <= 1'b1;
          idx        <= idx + 1'b1;
          if ({1'b0, idx} == n_reg - 1'b1) state <= DRAIN;
        end
        DRAIN: begin
          pipe_valid <= 1'b0;
          state      <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_pipelined_accumulator_engine.sv
// tb/tb_pipelined_accumulator_engine.sv - scoreboard bench for pipelined_accumulator_engine
module tb_pipelined_accumulator_engine;

  localparam int WIDTH = 32;
  localparam int DEPTH = 64;
  localparam int AW = 6;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             start = 1'b0;
  logic [AW:0]      len = '0;
  logic             mode = 1'b0;
  logic             busy, done, overflow;
  logic [WIDTH-1:0] sum;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             o;
    string            name;
  } exp_t;
  exp_t exp_q[$];

  pipelined_accumulator_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .len(len), .mode(mode), .busy(busy), .done(done),
    .sum(sum), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=sum %0h required=no done", sum);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_sum"}, sum, e.s);
        check({e.name, "_ovf"}, {31'b0, overflow}, {31'b0, e.o});
      end
    end
  end

  task automatic wr(input int a, input logic [WIDTH-1:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic start_run(input int l, input logic m, input bit push,
                           input logic [WIDTH-1:0] es, input logic eo, input string name);
    exp_t e;
    @(negedge clk);
    start = 1'b1; len = (AW+1)'(l); mode = m;
    if (push) begin
      e.s = es; e.o = eo; e.name = name;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called right after start_run: edges counts from the start edge inclusive.
  task automatic wait_done(input string name, output int edges, output int busy_cnt);
    edges = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && edges < 300) begin
      @(negedge clk);
      edges++;
      if (busy) busy_cnt++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no done required=done", name);
    end
  endtask

  initial begin
    int edges, bc;
    logic [WIDTH-1:0] e2, e3;
`ifdef ACC_SATURATE_EN
    e2 = 32'h0;        e3 = 32'hFFFF_FFFF;
`else
    e2 = 32'hFFFF_FFF8; e3 = 32'h1;
`endif

    @(negedge clk);
    check("rst_sum", sum, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_ovf", {31'b0, overflow}, 0);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) wr(i, WIDTH'(i + 1));
    start_run(8, 1'b0, 1'b1, 36, 1'b0, "t1");
    wait_done("t1", edges, bc);
    check("t1_latency", edges, 10);
    check("t1_busy_cycles", bc, 9);

    wr(0, 5); wr(1, 3);
    start_run(2, 1'b1, 1'b1, e2, 1'b1, "t2");
    wait_done("t2", edges, bc);

    wr(0, 32'hFFFF_FFFF); wr(1, 2);
    start_run(2, 1'b0, 1'b1, e3, 1'b1, "t3");
    wait_done("t3", edges, bc);

    start_run(0, 1'b0, 1'b1, 0, 1'b0, "t4_len0");
    wait_done("t4_len0", edges, bc);
    check("t4_len0_latency", edges, 1);
    check("t4_len0_busy", bc, 0);

    for (int i = 0; i < DEPTH; i++) wr(i, WIDTH'(i + 1));
    start_run(100, 1'b0, 1'b1, 2080, 1'b0, "t4_clamp");
    wait_done("t4_clamp", edges, bc);
    check("t4_clamp_latency", edges, 66);

    start_run(1, 1'b0, 1'b1, 1, 1'b0, "t4_len1");
    wait_done("t4_len1", edges, bc);
    check("t4_len1_latency", edges, 3);

    // Start and write while running must both be ignored.
    start_run(8, 1'b0, 1'b1, 36, 1'b0, "t5");
    repeat (2) @(negedge clk);
    start = 1'b1; len = 7'd3; wr_en = 1'b1; wr_addr = '0; wr_data = 999;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    wait_done("t5", edges, bc);
    start_run(1, 1'b0, 1'b1, 1, 1'b0, "t5_tbl0");
    wait_done("t5_tbl0", edges, bc);

    // Write and start in the same idle cycle: run sees the new value.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = '0; wr_data = 100;
    start = 1'b1; len = 7'd1; mode = 1'b0;
    begin
      exp_t e;
      e.s = 100; e.o = 1'b0; e.name = "wr_start";
      exp_q.push_back(e);
    end
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    wait_done("wr_start", edges, bc);
    wr(0, 1);

    // Reset mid-run aborts with no done pulse.
    start_run(64, 1'b0, 1'b0, 0, 1'b0, "t6");
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    check("t6_sum_abort", sum, 0);
    check("t6_busy_abort", {31'b0, busy}, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (80) @(negedge clk);
    check("t6_idle_busy", {31'b0, busy}, 0);
    start_run(8, 1'b0, 1'b1, 36, 1'b0, "t6_rerun");
    wait_done("t6_rerun", edges, bc);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
